// File: rtl/riscv_writeback_unit.sv
// rtl/riscv_writeback_unit.sv - register bank write-port arbiter for ALU and buffered load results
// Optional forwarding taps are enabled with the RISCV_WB_FWD_EN macro.
module riscv_writeback_unit #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_stall,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_w_en,
  output logic [4:0]      rf_r_write,
  output logic [XLEN-1:0] rf_w_data,
  output logic            busy
`ifdef RISCV_WB_FWD_EN
  ,
  input  logic [4:0]      fwd_ra,
  input  logic [4:0]      fwd_rb,
  output logic            fwd_a_hit,
  output logic            fwd_b_hit,
  output logic [XLEN-1:0] fwd_a_data,
  output logic [XLEN-1:0] fwd_b_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [SW-1:0]   starve_cnt;
  logic [SW-1:0]   starve_next;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            alu_win;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;

  // Readiness comes from the registered count only, so a same-cycle pop never
  // opens room for a push; likewise pop sees the registered count, so a load
  // pushed this cycle cannot be popped until the next one.
  assign fifo_empty = (count == '0);
  assign ld_ready   = (count < CW'(DEPTH));
  assign push       = ld_valid && ld_ready;
  assign alu_win    = alu_valid && !alu_stall;
  assign pop        = !alu_win && !fifo_empty;
  assign head_rd    = fifo_rd[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];
  assign busy       = !fifo_empty || rf_w_en;

  // Next occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Count consecutive cycles the FIFO waited while the ALU took the port
  always_comb begin
    starve_next = '0;
    if (!fifo_empty && alu_win && !pop) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Load FIFO storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // FIFO pointers, occupancy, starvation tracking and the one-cycle ALU stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count      <= count_next;
      starve_cnt <= starve_next;
      alu_stall  <= (starve_next == SW'(STARVE_LIMIT));
    end
  end

  // Register the arbitration winner onto the bank write port; x0 targets
  // consume the slot but never raise the enable, and address/data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en    <= 1'b0;
      rf_r_write <= '0;
      rf_w_data  <= '0;
    end else if (alu_win) begin
      rf_w_en <= (alu_rd != 5'd0);
      if (alu_rd != 5'd0) begin
        rf_r_write <= alu_rd;
        rf_w_data  <= alu_data;
      end
    end else if (pop) begin
      rf_w_en <= (head_rd != 5'd0);
      if (head_rd != 5'd0) begin
        rf_r_write <= head_rd;
        rf_w_data  <= head_data;
      end
    end else begin
      rf_w_en <= 1'b0;
    end
  end

`ifdef RISCV_WB_FWD_EN
  // Bypass the write in flight, which the bank's read ports cannot see yet
  assign fwd_a_hit  = rf_w_en && (rf_r_write == fwd_ra) && (fwd_ra != 5'd0);
  assign fwd_b_hit  = rf_w_en && (rf_r_write == fwd_rb) && (fwd_rb != 5'd0);
  assign fwd_a_data = fwd_a_hit ? rf_w_data : '0;
  assign fwd_b_data = fwd_b_hit ? rf_w_data : '0;
`endif

endmodule

// File: tb/tb_riscv_writeback_unit.sv
// tb/tb_riscv_writeback_unit.sv - scoreboard bench for riscv_writeback_unit
module tb_riscv_writeback_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_stall;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            rf_w_en;
  logic [4:0]      rf_r_write;
  logic [XLEN-1:0] rf_w_data;
  logic            busy;
`ifdef RISCV_WB_FWD_EN
  logic [4:0]      fwd_ra;
  logic [4:0]      fwd_rb;
  logic            fwd_a_hit;
  logic            fwd_b_hit;
  logic [XLEN-1:0] fwd_a_data;
  logic [XLEN-1:0] fwd_b_data;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [XLEN+4:0] q_alu[$];
  logic [XLEN+4:0] q_ld[$];

  riscv_writeback_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .rf_w_en    (rf_w_en),
    .rf_r_write (rf_r_write),
    .rf_w_data  (rf_w_data),
    .busy       (busy)
`ifdef RISCV_WB_FWD_EN
    ,
    .fwd_ra     (fwd_ra),
    .fwd_rb     (fwd_rb),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_data (fwd_b_data)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed bank write must match the oldest pending ALU
  // result or, failing that, the oldest pending load result.
  always @(negedge clk) begin
    logic [XLEN+4:0] got;
    if (rst_n && rf_w_en) begin
      got = {rf_r_write, rf_w_data};
      tests_run++;
      if (rf_r_write == 5'd0) begin
        tests_failed++;
        $display("FAIL sb_x0_write: got rd=%0d data=%h, required no write to x0", rf_r_write, rf_w_data);
      end else if (q_alu.size() > 0 && q_alu[0] === got) begin
        void'(q_alu.pop_front());
      end else if (q_ld.size() > 0) begin
        if (q_ld[0] !== got) begin
          tests_failed++;
          $display("FAIL sb_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_r_write, rf_w_data, q_ld[0][XLEN+4:XLEN], q_ld[0][XLEN-1:0]);
        end
        void'(q_ld.pop_front());
      end else begin
        tests_failed++;
        $display("FAIL sb_unexpected: got rd=%0d data=%h, required no write", rf_r_write, rf_w_data);
      end
    end
  end

  task automatic step(output logic alu_acc, output logic ld_acc);
    alu_acc = alu_valid && !alu_stall;
    ld_acc  = ld_valid && ld_ready;
    if (alu_acc && alu_rd != 5'd0) q_alu.push_back({alu_rd, alu_data});
    if (ld_acc && ld_rd != 5'd0) q_ld.push_back({ld_rd, ld_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    logic a, l;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    step(a, l);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && busy; i++) idle_step();
    tests_run++;
    if (busy !== 1'b0 || q_alu.size() != 0 || q_ld.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: busy=%b pending_alu=%0d pending_ld=%0d, required busy=0 pending 0/0",
               name, busy, q_alu.size(), q_ld.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_rd = '0; alu_data = '0; ld_rd = '0; ld_data = '0;
`ifdef RISCV_WB_FWD_EN
    fwd_ra = '0; fwd_rb = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rf_w_en, rf_r_write, rf_w_data, ld_ready, busy, alu_stall} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got w_en=%b r_write=%0d w_data=%h ld_ready=%b busy=%b stall=%b, required 0 0 0 1 0 0",
               rf_w_en, rf_r_write, rf_w_data, ld_ready, busy, alu_stall);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_only();
    logic a, l;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678; ld_valid = 1'b0;
    step(a, l);
    tests_run++;
    if ({rf_w_en, rf_r_write, rf_w_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL alu_write: got w_en=%b rd=%0d data=%h, required 1 5 12345678", rf_w_en, rf_r_write, rf_w_data);
    end
    idle_step();
    tests_run++;
    if (rf_w_en !== 1'b0 || rf_r_write !== 5'd5 || rf_w_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL alu_after: got w_en=%b rd=%0d data=%h, required 0 with held 5 12345678", rf_w_en, rf_r_write, rf_w_data);
    end
    drain("alu_only");
  endtask

  task automatic test_load_idle();
    logic a, l;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hDEAD_B0DE; alu_valid = 1'b0;
    step(a, l);
    tests_run++;
    if (busy !== 1'b1 || rf_w_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_t1: got busy=%b w_en=%b, required busy=1 w_en=0", busy, rf_w_en);
    end
    idle_step();
    tests_run++;
    if ({rf_w_en, rf_r_write, rf_w_data, busy} !== {1'b1, 5'd9, 32'hDEAD_B0DE, 1'b1}) begin
      tests_failed++;
      $display("FAIL load_t2: got w_en=%b rd=%0d data=%h busy=%b, required 1 9 deadb0de 1",
               rf_w_en, rf_r_write, rf_w_data, busy);
    end
    idle_step();
    tests_run++;
    if (rf_w_en !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_t3: got w_en=%b busy=%b, required 0 0", rf_w_en, busy);
    end
  endtask

  task automatic test_collision();
    logic a, l;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h0000_0444;
    step(a, l);
    tests_run++;
    if ({rf_w_en, rf_r_write, rf_w_data} !== {1'b1, 5'd3, 32'h0000_0333}) begin
      tests_failed++;
      $display("FAIL collide_alu: got w_en=%b rd=%0d data=%h, required 1 3 00000333", rf_w_en, rf_r_write, rf_w_data);
    end
    idle_step();
    tests_run++;
    if ({rf_w_en, rf_r_write, rf_w_data} !== {1'b1, 5'd4, 32'h0000_0444}) begin
      tests_failed++;
      $display("FAIL collide_ld: got w_en=%b rd=%0d data=%h, required 1 4 00000444", rf_w_en, rf_r_write, rf_w_data);
    end
    drain("collision");
  endtask

  task automatic test_back_to_back();
    logic a, l;
    int k = 0;
    int n = 0;
    int stalls = 0;
    logic rdy_at[20];
    logic stl_at[20];
    for (int i = 0; i < 20; i++) begin
      rdy_at[i] = ld_ready;
      stl_at[i] = alu_stall;
      if (alu_stall) stalls++;
      alu_valid = 1'b1;
      alu_rd    = 5'(16 + (n % 15));
      alu_data  = 32'hA000_0000 + 32'(n);
      ld_valid  = (k < 5);
      ld_rd     = 5'(k + 1);
      ld_data   = 32'hB000_0000 + 32'(k);
      step(a, l);
      if (a) n++;
      if (l) k++;
    end
    tests_run++;
    if (rdy_at[3] !== 1'b1 || rdy_at[4] !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready: got ld_ready c3=%b c4=%b, required 1 0", rdy_at[3], rdy_at[4]);
    end
    tests_run++;
    if (stl_at[3] !== 1'b0 || stl_at[4] !== 1'b1 || stl_at[5] !== 1'b0) begin
      tests_failed++;
      $display("FAIL starve_pulse: got stall c3=%b c4=%b c5=%b, required 0 1 0", stl_at[3], stl_at[4], stl_at[5]);
    end
    tests_run++;
    if (stalls != 4 || k != 5) begin
      tests_failed++;
      $display("FAIL starve_count: got stalls=%0d loads_accepted=%0d, required 4 5", stalls, k);
    end
    drain("back_to_back");
  endtask

  task automatic test_x0();
    logic a, l;
    int wr_seen = 0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_0000;
    ld_valid  = 1'b1; ld_rd  = 5'd0; ld_data  = 32'h0000_FFFF;
    step(a, l);
    if (rf_w_en) wr_seen++;
    for (int i = 0; i < 3; i++) begin
      idle_step();
      if (rf_w_en) wr_seen++;
    end
    tests_run++;
    if (wr_seen != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL x0_filter: got writes=%0d busy=%b, required 0 0", wr_seen, busy);
    end
  endtask

  task automatic test_reset_midop();
    logic a, l;
    int wr_seen = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'hC000_0000 + 32'(i);
      ld_valid  = 1'b1; ld_rd  = 5'(10 + i); ld_data  = 32'hD000_0000 + 32'(i);
      step(a, l);
    end
`ifdef RISCV_WB_FWD_EN
    fwd_ra = 5'd22; fwd_rb = 5'd0;
    #1;
    tests_run++;
    if (fwd_a_hit !== 1'b1 || fwd_a_data !== 32'hC000_0002 || fwd_b_hit !== 1'b0 || fwd_b_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL fwd_hit: got a_hit=%b a_data=%h b_hit=%b b_data=%h, required 1 c0000002 0 0",
               fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data);
    end
    fwd_ra = 5'd0;
    #1;
    tests_run++;
    if (fwd_a_hit !== 1'b0 || fwd_a_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL fwd_x0: got a_hit=%b a_data=%h, required 0 0", fwd_a_hit, fwd_a_data);
    end
`endif
    tests_run++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_pre: got busy=%b ld_ready=%b, required 1 1", busy, ld_ready);
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    rst_n = 1'b0;
    q_alu.delete();
    q_ld.delete();
    #1;
    tests_run++;
    if (rf_w_en !== 1'b0 || ld_ready !== 1'b1 || busy !== 1'b0 || alu_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset: got w_en=%b ld_ready=%b busy=%b stall=%b, required 0 1 0 0",
               rf_w_en, ld_ready, busy, alu_stall);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle_step();
      if (rf_w_en) wr_seen++;
    end
    tests_run++;
    if (wr_seen != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_stale: got writes=%0d busy=%b, required 0 0", wr_seen, busy);
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load_idle();
    test_collision();
    test_back_to_back();
    test_x0();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
